// File: rtl/reg_status_table_if.sv
// Dispatch, CDB and lookup signals of the register status table.
// master drives dispatch/CDB/lookups; slave is the table.
interface reg_status_table_if #(
  parameter int TAG_WIDTH = 6
);
  logic                 flush;
  logic                 disp_en;
  logic [4:0]           disp_rd;
  logic [TAG_WIDTH-1:0] disp_tag;
  logic                 cdb_valid;
  logic [TAG_WIDTH-1:0] cdb_tag;
  logic [4:0]           rs1_addr;
  logic [4:0]           rs2_addr;
  logic                 rs1_busy;
  logic                 rs2_busy;
  logic [TAG_WIDTH-1:0] rs1_tag;
  logic [TAG_WIDTH-1:0] rs2_tag;
  logic [5:0]           busy_count;

  modport master (
    output flush, disp_en, disp_rd, disp_tag, cdb_valid, cdb_tag, rs1_addr, rs2_addr,
    input  rs1_busy, rs2_busy, rs1_tag, rs2_tag, busy_count
  );

  modport slave (
    input  flush, disp_en, disp_rd, disp_tag, cdb_valid, cdb_tag, rs1_addr, rs2_addr,
    output rs1_busy, rs2_busy, rs1_tag, rs2_tag, busy_count
  );
endinterface

// File: rtl/reg_status_table.sv
// Register status table: per-register busy bit and producer tag, cleared by CDB broadcasts.
// Optional macro RST_CDB_BYPASS_EN makes a same-cycle CDB match read as not busy.
module reg_status_table #(
  parameter int NUM_REGS  = 32,
  parameter int TAG_WIDTH = 6
) (
  input logic               i_clk,
  input logic               i_rst_n,
  reg_status_table_if.slave bus
);

  localparam int SLOTS = 32;

  // Entry 0 and any slot beyond NUM_REGS can never become busy.
  function automatic logic [SLOTS-1:0] valid_mask_f();
    logic [SLOTS-1:0] m;
    m = '0;
    for (int i = 1; i < SLOTS; i++) m[i] = (i < NUM_REGS);
    return m;
  endfunction

  localparam logic [SLOTS-1:0] VALID_MASK = valid_mask_f();

  function automatic logic [5:0] popcount(input logic [SLOTS-1:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < SLOTS; i++) c = c + 6'(v[i]);
    return c;
  endfunction

  logic [SLOTS-1:0]     busy_q, busy_d;
  logic [TAG_WIDTH-1:0] tag_q [SLOTS];
  logic [TAG_WIDTH-1:0] tag_d [SLOTS];
  logic [5:0]           busy_count_q;

  // NOTE: every signal written here gets its default first, so no path leaves it unassigned (no latch).
  always_comb begin
    busy_d = busy_q;
    tag_d  = tag_q;
    if (bus.flush) begin
      busy_d = '0;
    end else begin
      if (bus.cdb_valid) begin
        for (int i = 0; i < SLOTS; i++) begin
          if (busy_q[i] && (tag_q[i] == bus.cdb_tag)) busy_d[i] = 1'b0;
        end
      end
      // Dispatch is applied after the CDB clear so it wins on the same entry.
      if (bus.disp_en && VALID_MASK[bus.disp_rd]) begin
        busy_d[bus.disp_rd] = 1'b1;
        tag_d[bus.disp_rd]  = bus.disp_tag;
      end
    end
    busy_d = busy_d & VALID_MASK;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      busy_q       <= '0;
      busy_count_q <= '0;
      // NOTE: the tag array is reset too, because tags must read as 0 out of reset.
      for (int i = 0; i < SLOTS; i++) tag_q[i] <= '0;
    end else begin
      busy_q       <= busy_d;
      tag_q        <= tag_d;
      busy_count_q <= popcount(busy_d);
    end
  end

  logic [4:0]           rd_addr [2];
  logic                 rd_busy [2];
  logic [TAG_WIDTH-1:0] rd_tag  [2];

  assign rd_addr[0] = bus.rs1_addr;
  assign rd_addr[1] = bus.rs2_addr;

  // Lookups read table state only; a same-cycle dispatch is not forwarded.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_busy[p] = busy_q[rd_addr[p]] & i_rst_n;
`ifdef RST_CDB_BYPASS_EN
      if (bus.cdb_valid && (tag_q[rd_addr[p]] == bus.cdb_tag)) rd_busy[p] = 1'b0;
`endif
      rd_tag[p] = rd_busy[p] ? tag_q[rd_addr[p]] : '0;
    end
  end

  assign bus.rs1_busy   = rd_busy[0];
  assign bus.rs2_busy   = rd_busy[1];
  assign bus.rs1_tag    = rd_tag[0];
  assign bus.rs2_tag    = rd_tag[1];
  assign bus.busy_count = busy_count_q;

endmodule

// File: tb/tb_reg_status_table.sv
// Self-checking bench for reg_status_table: directed scenarios plus random traffic
// against an array-based model of the busy/tag rules.
module tb_reg_status_table;

  localparam int TW = 6;
  localparam int NR = 32;

  logic i_clk = 1'b0;
  logic i_rst_n;

  always #5 i_clk = ~i_clk;

  reg_status_table_if #(.TAG_WIDTH(TW)) bus ();

  reg_status_table #(.NUM_REGS(NR), .TAG_WIDTH(TW)) dut (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .bus    (bus)
  );

  bit          m_busy [NR];
  logic [TW-1:0] m_tag [NR];
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < NR; i++) c += int'(m_busy[i]);
    return c;
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
    logic b;
    if (a == 5'd0) return 1'b0;
    b = m_busy[a];
`ifdef RST_CDB_BYPASS_EN
    if (bus.cdb_valid && b && (m_tag[a] == bus.cdb_tag)) b = 1'b0;
`endif
    return b;
  endfunction

  function automatic logic [TW-1:0] exp_tag(input logic [4:0] a);
    return exp_busy(a) ? m_tag[a] : '0;
  endfunction

  task automatic check_outputs(input string where);
    check({where, ".rs1_busy"}, bus.rs1_busy, exp_busy(bus.rs1_addr));
    check({where, ".rs1_tag"},  bus.rs1_tag,  exp_tag(bus.rs1_addr));
    check({where, ".rs2_busy"}, bus.rs2_busy, exp_busy(bus.rs2_addr));
    check({where, ".rs2_tag"},  bus.rs2_tag,  exp_tag(bus.rs2_addr));
    check({where, ".count"},    bus.busy_count, m_count());
  endtask

  // Apply the table rules for one rising edge using the inputs currently driven.
  task automatic model_edge();
    bit nb [NR];
    if (bus.flush) begin
      for (int i = 0; i < NR; i++) m_busy[i] = 1'b0;
      return;
    end
    nb = m_busy;
    if (bus.cdb_valid)
      for (int i = 0; i < NR; i++)
        if (m_busy[i] && m_tag[i] == bus.cdb_tag) nb[i] = 1'b0;
    if (bus.disp_en && bus.disp_rd != 5'd0) begin
      nb[bus.disp_rd]    = 1'b1;
      m_tag[bus.disp_rd] = bus.disp_tag;
    end
    m_busy = nb;
  endtask

  task automatic drive(input logic en, input logic [4:0] rd, input logic [TW-1:0] tg,
                       input logic cv, input logic [TW-1:0] ct, input logic fl,
                       input logic [4:0] a1, input logic [4:0] a2);
    bus.disp_en   = en;
    bus.disp_rd   = rd;
    bus.disp_tag  = tg;
    bus.cdb_valid = cv;
    bus.cdb_tag   = ct;
    bus.flush     = fl;
    bus.rs1_addr  = a1;
    bus.rs2_addr  = a2;
  endtask

  // Called between negedge and posedge: drive, check, clock, update model, return after negedge.
  task automatic cycle(input string where, input logic en, input logic [4:0] rd,
                       input logic [TW-1:0] tg, input logic cv, input logic [TW-1:0] ct,
                       input logic fl, input logic [4:0] a1, input logic [4:0] a2);
    drive(en, rd, tg, cv, ct, fl, a1, a2);
    #1;
    check_outputs(where);
    @(posedge i_clk);
    model_edge();
    @(negedge i_clk);
  endtask

  task automatic idle_look(input logic [4:0] a1, input logic [4:0] a2);
    drive(1'b0, 5'd0, '0, 1'b0, '0, 1'b0, a1, a2);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0]    rd, a1, a2;
    logic [TW-1:0] tg, ct;
    logic          en, cv, fl;

    for (int i = 0; i < NR; i++) begin
      m_busy[i] = 1'b0;
      m_tag[i]  = '0;
    end

    // Reset with a dispatch pending: it must be discarded.
    i_rst_n = 1'b1;
    drive(1'b1, 5'd3, 6'd9, 1'b0, '0, 1'b0, 5'd3, 5'd0);
    #2 i_rst_n = 1'b0;
    #2;
    check("rst.count", bus.busy_count, 0);
    check("rst.rs1_busy", bus.rs1_busy, 0);
    check("rst.rs1_tag", bus.rs1_tag, 0);
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    idle_look(5'd3, 5'd0);
    check("rst_release.rs1_busy", bus.rs1_busy, 0);
    check("rst_release.count", bus.busy_count, 0);

    // Dispatch rd=5 tag=12; no same-cycle forwarding.
    cycle("disp5", 1'b1, 5'd5, 6'd12, 1'b0, '0, 1'b0, 5'd5, 5'd0);
    idle_look(5'd5, 5'd0);
    check("disp5.busy", bus.rs1_busy, 1);
    check("disp5.tag", bus.rs1_tag, 12);
    check("disp5.count", bus.busy_count, 1);

    // CDB broadcast of tag 12.
    drive(1'b0, 5'd0, '0, 1'b1, 6'd12, 1'b0, 5'd5, 5'd5);
    #1;
`ifdef RST_CDB_BYPASS_EN
    check("cdb12.same_cycle_busy", bus.rs1_busy, 0);
`else
    check("cdb12.same_cycle_busy", bus.rs1_busy, 1);
`endif
    cycle("cdb12", 1'b0, 5'd0, '0, 1'b1, 6'd12, 1'b0, 5'd5, 5'd5);
    idle_look(5'd5, 5'd0);
    check("cdb12.next_busy", bus.rs1_busy, 0);
    check("cdb12.count", bus.busy_count, 0);

    // Dispatch and CDB on the same entry: dispatch wins.
    cycle("re5", 1'b1, 5'd5, 6'd12, 1'b0, '0, 1'b0, 5'd5, 5'd0);
    cycle("prio", 1'b1, 5'd5, 6'd20, 1'b1, 6'd12, 1'b0, 5'd5, 5'd0);
    idle_look(5'd5, 5'd0);
    check("prio.busy", bus.rs1_busy, 1);
    check("prio.tag", bus.rs1_tag, 20);
    check("prio.count", bus.busy_count, 1);

    // CDB clears one entry while dispatch writes another.
    cycle("indep", 1'b1, 5'd8, 6'd33, 1'b1, 6'd20, 1'b0, 5'd5, 5'd8);
    idle_look(5'd5, 5'd8);
    check("indep.rs1_busy", bus.rs1_busy, 0);
    check("indep.rs2_tag", bus.rs2_tag, 33);

    // Dispatch to register 0 is ignored.
    cycle("rd0", 1'b1, 5'd0, 6'd3, 1'b0, '0, 1'b0, 5'd0, 5'd0);
    idle_look(5'd0, 5'd8);
    check("rd0.busy", bus.rs1_busy, 0);
    check("rd0.count", bus.busy_count, 1);

    // Fill 1..31, then flush against a dispatch.
    for (int r = 1; r < NR; r++)
      cycle("fill", 1'b1, 5'(r), TW'(r + 32), 1'b0, '0, 1'b0, 5'(r), 5'(r - 1));
    idle_look(5'd31, 5'd7);
    check("fill.count", bus.busy_count, 31);
    cycle("flush", 1'b1, 5'd7, 6'd9, 1'b0, '0, 1'b1, 5'd7, 5'd1);
    idle_look(5'd7, 5'd1);
    check("flush.rs1_busy", bus.rs1_busy, 0);
    check("flush.count", bus.busy_count, 0);

    // Random traffic with a small tag space so CDB hits are frequent.
    for (int n = 0; n < 400; n++) begin
      en = 1'($urandom_range(0, 3) != 0);
      rd = 5'($urandom_range(0, 31));
      tg = TW'($urandom_range(0, 15));
      cv = 1'($urandom_range(0, 1));
      ct = ($urandom_range(0, 1) != 0) ? m_tag[$urandom_range(1, NR - 1)] : TW'($urandom_range(0, 15));
      fl = 1'($urandom_range(0, 40) == 0);
      a1 = 5'($urandom_range(0, 31));
      a2 = 5'($urandom_range(0, 31));
      cycle("rand", en, rd, tg, cv, ct, fl, a1, a2);
    end

    // Asynchronous reset asserted mid-cycle with entries busy.
    cycle("pre_rst_a", 1'b1, 5'd4, 6'd5, 1'b0, '0, 1'b0, 5'd4, 5'd0);
    cycle("pre_rst_b", 1'b1, 5'd6, 6'd7, 1'b0, '0, 1'b0, 5'd4, 5'd6);
    drive(1'b1, 5'd9, 6'd1, 1'b0, '0, 1'b0, 5'd4, 5'd6);
    #2 i_rst_n = 1'b0;
    #1;
    check("midrst.count", bus.busy_count, 0);
    check("midrst.rs1_busy", bus.rs1_busy, 0);
    check("midrst.rs1_tag", bus.rs1_tag, 0);
    check("midrst.rs2_busy", bus.rs2_busy, 0);
    for (int i = 0; i < NR; i++) begin
      m_busy[i] = 1'b0;
      m_tag[i]  = '0;
    end
    @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    idle_look(5'd9, 5'd4);
    check("midrst_release.rs1_busy", bus.rs1_busy, 0);
    check("midrst_release.count", bus.busy_count, 0);
    cycle("post_rst", 1'b1, 5'd9, 6'd2, 1'b0, '0, 1'b0, 5'd9, 5'd0);
    cycle("post_rst_look", 1'b0, 5'd0, '0, 1'b0, '0, 1'b0, 5'd9, 5'd4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/reg_status_table.md
REG_STATUS_TABLE -- requirements
Module: reg_status_table

Interface
REQ-001 SHALL provide parameter NUM_REGS, default 32, number of architectural registers tracked.
REQ-002 SHALL provide parameter TAG_WIDTH, default 6, width of a rename tag from the tag FIFO.
REQ-003 SHALL have i_clk  input  1  clock, all state updates on rising edge.
REQ-004 SHALL have i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have flush  input  1  synchronous pipeline flush.
REQ-006 SHALL have disp_en  input  1  dispatch of an instruction that writes a destination register.
REQ-007 SHALL have disp_rd  input  5  destination register index of the dispatched instruction.
REQ-008 SHALL have disp_tag  input  TAG_WIDTH  tag allocated to that instruction by the tag FIFO.
REQ-009 SHALL have cdb_valid  input  1  CDB broadcast valid; cdb_tag  input  TAG_WIDTH  broadcast tag.
REQ-010 SHALL have rs1_addr, rs2_addr  input  5 each  source register lookup indices.
REQ-011 SHALL have rs1_busy, rs2_busy  output  1 each  source has a pending producer.
REQ-012 SHALL have rs1_tag, rs2_tag  output  TAG_WIDTH each  tag of the pending producer.
REQ-013 SHALL have busy_count  output  6  number of entries currently busy (0..31).

Function
REQ-014 SHALL hold per register one busy bit and one TAG_WIDTH tag field; register 0 never busy.
REQ-015 SHALL, on disp_en=1 and disp_rd!=0, set entry disp_rd busy=1, tag=disp_tag at the next edge, overwriting any previous mapping.
REQ-016 SHALL ignore disp_en when disp_rd=0.
REQ-017 SHALL, on cdb_valid=1, clear busy at the next edge for every busy entry whose tag equals cdb_tag.
REQ-018 SHALL give dispatch priority when the same edge dispatches to an entry and the CDB matches that entry's old tag: entry ends busy with disp_tag.
REQ-019 SHALL clear a CDB-matched entry and write a different disp_rd entry in the same edge independently.
REQ-020 SHALL drive rsN_busy/rsN_tag combinationally from table state for rsN_addr; rsN_tag=0 when rsN_busy=0; addr 0 gives busy=0, tag=0.
REQ-021 SHALL NOT forward same-cycle dispatch to read ports (an instruction reading its own rd sees the prior producer).
REQ-022 SHALL, on flush=1, clear all busy bits and busy_count to 0 at the next edge, overriding dispatch and CDB in that cycle; tag fields unchanged.
REQ-023 SHALL register busy_count as the population count of busy bits after each edge (zero-cycle lag relative to table).
REQ-024 SHALL never let busy_count exceed NUM_REGS-1.

Reset
REQ-025 SHALL, while i_rst_n=0, asynchronously force all busy bits, tag fields and busy_count to 0.
REQ-026 SHALL drive rs1_busy=rs2_busy=0 and rs1_tag=rs2_tag=0 during reset regardless of inputs.
REQ-027 SHALL discard a dispatch or CDB event coincident with reset assertion; first update on first edge after deassertion.

Configuration
REQ-028 SHALL support macro RST_CDB_BYPASS_EN.
REQ-029 SHALL, with RST_CDB_BYPASS_EN defined, report rsN_busy=0, rsN_tag=0 in the same cycle when cdb_valid=1 and the looked-up entry is busy with tag==cdb_tag.
REQ-030 SHALL, without RST_CDB_BYPASS_EN, report the matched entry busy until the edge that clears it (one-cycle later visibility).

Verification
REQ-031 Reset then dispatch rd=5 tag=12 -> next cycle rs1_addr=5 gives busy=1 tag=12, busy_count=1.
REQ-032 Entry 5 busy tag 12, cdb_valid=1 tag=12 -> bypass build: rs1_busy=0 same cycle; non-bypass: busy=1 same cycle, 0 next; busy_count=0.
REQ-033 Entry 5 busy tag 12, same cycle dispatch rd=5 tag=20 and CDB tag=12 -> entry 5 busy tag 20, busy_count=1.
REQ-034 Dispatch rd=0 tag=3 -> rs1_addr=0 busy=0, busy_count unchanged.
REQ-035 Entries 1..31 busy, flush=1 with dispatch rd=7 same cycle -> all busy=0, busy_count=0 next cycle.
REQ-036 Assert i_rst_n=0 mid-cycle with entries busy -> outputs and busy_count 0 immediately, before next edge.
